// File: rtl/systolic_pkg.sv
// Shared types for the systolic step sequencer.
// Holds the FSM state encoding and the default operand width.
package systolic_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/systolic_step_seq_if.sv
// Operand-in and step-out handshake bundle.
// master drives operands and step_ready; slave is the sequencer.
interface systolic_step_seq_if
  import systolic_pkg::*;
#(
  parameter int M  = 8,
  parameter int N  = 8,
  parameter int DW = DW_DEF
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [M-1:0][DW-1:0]   in_a;
  logic [N-1:0][DW-1:0]   in_b;
  logic                   step_valid;
  logic                   step_ready;
  logic [M-1:0][DW-1:0]   step_a;
  logic [N-1:0][DW-1:0]   step_b;
  logic                   k_first;
  logic                   k_last;
  logic [15:0]            k_idx;

  modport master (
    output in_valid, in_a, in_b, step_ready,
    input  in_ready, step_valid, step_a, step_b,
    input  k_first, k_last, k_idx
  );

  modport slave (
    input  in_valid, in_a, in_b, step_ready,
    output in_ready, step_valid, step_a, step_b,
    output k_first, k_last, k_idx
  );

endinterface

// File: rtl/systolic_step_fifo.sv
// Step operand FIFO; pointers wrap modulo DEPTH.
// Storage is unreset; only pointers and count clear.
module systolic_step_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/systolic_step_seq.sv
// Tile sequencer: buffers K operand words, issues
// them as array steps, waits for the array to drain.
module systolic_step_seq
  import systolic_pkg::*;
#(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         K,
  input  logic                acc_mode,
  input  logic                abort,
  input  logic                done_clear,
  input  logic                arr_idle,
  output logic                busy,
  output logic                done,
  output logic                err_k_zero,
  systolic_step_seq_if.slave  bus
);

  localparam int FW = (M + N) * DW;

  state_t        state;
  logic [15:0]   k_len;
  logic [15:0]   in_cnt;
  logic [15:0]   k_idx;
  logic          acc;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          flush;
  logic          launch;
  logic [FW-1:0] head;

  assign bus.in_ready   = (state == RUN) && !full
                          && (in_cnt < k_len);
  assign bus.step_valid = (state == RUN) && !empty;
  assign {bus.step_a, bus.step_b} = head;
  assign bus.k_idx      = k_idx;
  assign bus.k_first    = bus.step_valid
                          && (k_idx == '0) && !acc;
  assign bus.k_last     = bus.step_valid
                          && (k_idx == k_len - 16'd1);

  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = bus.step_valid && bus.step_ready;
  assign flush  = abort && busy;
  // start in DONE wins over done_clear
  assign launch = start
                  && ((state == IDLE) || (state == DONE));

  systolic_step_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   ({bus.in_a, bus.in_b}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      k_len      <= '0;
      in_cnt     <= '0;
      k_idx      <= '0;
      acc        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_k_zero <= 1'b0;
    end else if (launch) begin
      k_len  <= K;
      acc    <= acc_mode;
      in_cnt <= '0;
      k_idx  <= '0;
      if (K == '0) begin
        state      <= DONE;
        busy       <= 1'b0;
        done       <= 1'b1;
        err_k_zero <= 1'b1;
      end else begin
        state      <= RUN;
        busy       <= 1'b1;
        done       <= 1'b0;
        err_k_zero <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            in_cnt <= '0;
            k_idx  <= '0;
          end else begin
            if (push) in_cnt <= in_cnt + 16'd1;
            if (pop)  k_idx  <= k_idx + 16'd1;
            if (pop && bus.k_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            in_cnt <= '0;
            k_idx  <= '0;
          end else if (arr_idle) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (done_clear) begin
            state      <= IDLE;
            done       <= 1'b0;
            err_k_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_step_seq.sv
// Directed bench for systolic_step_seq.
// Expected values are hand-derived per scenario.
module tb_systolic_step_seq;
  import systolic_pkg::*;

  localparam int M = 8, N = 8, DW = 32, DEPTH = 4;

  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic [15:0] K = '0;
  logic        acc_mode = 0;
  logic        abort = 0;
  logic        done_clear = 0;
  logic        arr_idle = 1;
  logic        busy, done, err_k_zero;

  int errs = 0;
  int checks = 0;
  int push_cnt = 0;

  logic [31:0] pat [4] = '{32'h3f800000, 32'h40000000,
                           32'h3f000000, 32'h40400000};

  logic [15:0] q_idx [$];
  logic        q_first [$];
  logic        q_last [$];
  logic [31:0] q_a0 [$];
  logic [31:0] q_b0 [$];

  systolic_step_seq_if #(.M(M), .N(N), .DW(DW)) bus ();

  systolic_step_seq #(
    .M(M), .N(N), .DW(DW), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .K          (K),
    .acc_mode   (acc_mode),
    .abort      (abort),
    .done_clear (done_clear),
    .arr_idle   (arr_idle),
    .busy       (busy),
    .done       (done),
    .err_k_zero (err_k_zero),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // handshakes are stable mid-cycle; record what the
  // next rising edge will accept
  always @(negedge clk) begin
    if (rst && bus.step_valid && bus.step_ready) begin
      q_idx.push_back(bus.k_idx);
      q_first.push_back(bus.k_first);
      q_last.push_back(bus.k_last);
      q_a0.push_back(bus.step_a[0]);
      q_b0.push_back(bus.step_b[0]);
    end
    if (rst && bus.in_valid && bus.in_ready)
      push_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] b0_of(int w, int base);
    return {4'hb, 12'd0, 8'(base), 8'(w)};
  endfunction

  task automatic set_word(int w, int base);
    for (int i = 0; i < M; i++)
      bus.in_a[i] = (i == 0) ? pat[w % 4]
                  : {16'(base), 8'(w), 8'(i)};
    for (int j = 0; j < N; j++)
      bus.in_b[j] = {4'hb, 12'(j), 8'(base), 8'(w)};
  endtask

  task automatic push_words(int n, int w0, int base);
    for (int w = w0; w < w0 + n; w++) begin
      logic ok;
      int t;
      set_word(w, base);
      bus.in_valid = 1;
      ok = 0;
      t = 0;
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = bus.in_ready;
        tick();
        t++;
      end
      if (!ok) chk("push_timeout", ok, 1);
    end
    bus.in_valid = 0;
  endtask

  task automatic start_tile(int k, logic acc);
    K = 16'(k);
    acc_mode = acc;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_hs(int total);
    int t = 0;
    while (q_idx.size() < total && t < 300) begin
      tick();
      t++;
    end
    chk("hs_timeout", 64'(q_idx.size() >= total), 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin
      tick();
      t++;
    end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    int b;
    int p;
    bus.in_valid = 0;
    bus.step_ready = 1;
    set_word(0, 0);
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_k_zero, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_step_valid", bus.step_valid, 0);
    rst = 1;
    tick();

    // basic K=4 tile, delayed arr_idle
    arr_idle = 0;
    b = q_idx.size();
    start_tile(4, 0);
    chk("t1_busy", busy, 1);
    push_words(4, 0, 1);
    wait_hs(b + 4);
    repeat (2) tick();
    chk("t1_drain_busy", busy, 1);
    chk("t1_drain_done", done, 0);
    arr_idle = 1;
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_hs_cnt", q_idx.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_idx", q_idx[b+i], i);
      chk("t1_first", q_first[b+i], i == 0);
      chk("t1_last", q_last[b+i], i == 3);
    end

    // backpressure: start from DONE, FIFO fills at 4
    b = q_idx.size();
    p = push_cnt;
    bus.step_ready = 0;
    start_tile(8, 0);
    chk("t2_busy", busy, 1);
    chk("t2_done_clr", done, 0);
    fork
      push_words(8, 0, 2);
      begin
        repeat (10) tick();
        chk("t2_pushes", push_cnt - p, 4);
        chk("t2_in_ready", bus.in_ready, 0);
        chk("t2_step_valid", bus.step_valid, 1);
        bus.step_ready = 1;
      end
    join
    wait_hs(b + 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_idx", q_idx[b+i], i);
      chk("t2_a00", q_a0[b+i], pat[i % 4]);
      chk("t2_b00", q_b0[b+i], b0_of(i, 2));
    end
    wait_done();

    // K=0 error path
    done_clear = 1;
    tick();
    done_clear = 0;
    chk("t3_clr_done", done, 0);
    chk("t3_clr_busy", busy, 0);
    b = q_idx.size();
    start_tile(0, 0);
    chk("t3_done", done, 1);
    chk("t3_err", err_k_zero, 1);
    chk("t3_step_valid", bus.step_valid, 0);
    chk("t3_in_ready", bus.in_ready, 0);
    chk("t3_busy", busy, 0);
    tick();
    chk("t3_sticky", done & err_k_zero, 1);
    done_clear = 1;
    tick();
    done_clear = 0;
    chk("t3_done_clr", done, 0);
    chk("t3_err_clr", err_k_zero, 0);
    chk("t3_no_steps", q_idx.size() - b, 0);

    // accumulate mode
    b = q_idx.size();
    start_tile(2, 1);
    push_words(2, 0, 3);
    wait_hs(b + 2);
    wait_done();
    chk("t4_first0", q_first[b], 0);
    chk("t4_first1", q_first[b+1], 0);
    chk("t4_last0", q_last[b], 0);
    chk("t4_last1", q_last[b+1], 1);
    chk("t4_err", err_k_zero, 0);

    // start and done_clear together: start wins
    b = q_idx.size();
    K = 16'd1;
    acc_mode = 0;
    start = 1;
    done_clear = 1;
    tick();
    start = 0;
    done_clear = 0;
    chk("t5_busy", busy, 1);
    chk("t5_done", done, 0);
    push_words(1, 0, 4);
    wait_hs(b + 1);
    wait_done();
    chk("t5_first", q_first[b], 1);
    chk("t5_last", q_last[b], 1);

    // abort with one word buffered
    done_clear = 1;
    tick();
    done_clear = 0;
    b = q_idx.size();
    start_tile(4, 0);
    push_words(2, 0, 6);
    wait_hs(b + 2);
    bus.step_ready = 0;
    push_words(1, 2, 6);
    chk("t6_pre_sv", bus.step_valid, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_step_valid", bus.step_valid, 0);
    chk("t6_in_ready", bus.in_ready, 0);
    tick();
    chk("t6_idle_sv", bus.step_valid, 0);
    bus.step_ready = 1;
    b = q_idx.size();
    start_tile(4, 0);
    push_words(4, 0, 7);
    wait_hs(b + 4);
    wait_done();
    repeat (2) tick();
    chk("t6_hs_cnt", q_idx.size() - b, 4);
    chk("t6_idx0", q_idx[b], 0);
    chk("t6_b00", q_b0[b], b0_of(0, 7));
    chk("t6_last", q_last[b+3], 1);

    // reset in the middle of RUN
    done_clear = 1;
    tick();
    done_clear = 0;
    bus.step_ready = 0;
    start_tile(8, 0);
    push_words(3, 0, 8);
    chk("t7_pre_sv", bus.step_valid, 1);
    rst = 0;
    tick();
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_err", err_k_zero, 0);
    chk("t7_in_ready", bus.in_ready, 0);
    chk("t7_step_valid", bus.step_valid, 0);
    chk("t7_k_idx", bus.k_idx, 0);
    chk("t7_k_first", bus.k_first, 0);
    chk("t7_k_last", bus.k_last, 0);
    rst = 1;
    tick();
    bus.step_ready = 1;
    b = q_idx.size();
    start_tile(2, 0);
    push_words(2, 0, 9);
    wait_hs(b + 2);
    wait_done();
    repeat (3) tick();
    chk("t7_hs_cnt", q_idx.size() - b, 2);
    chk("t7_b00", q_b0[b], b0_of(0, 9));
    chk("t7_last", q_last[b+1], 1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/systolic_step_seq.md
SYSTOLIC_STEP_SEQ -- requirements
Module: systolic_step_seq

Interface
REQ-001 Parameters SHALL be: M, default 8, array rows; N, default 8, array columns; DW, default 32, operand width; DEPTH, default 4, step FIFO entries (power of 2, >=2).
REQ-002 clk  in  1  clock; all logic SHALL sample on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  launch a tile; ignored while busy.
REQ-005 K  in  16  number of k-steps; sampled on accepted start.
REQ-006 acc_mode  in  1  1 = accumulate onto existing psums; sampled on accepted start.
REQ-007 abort  in  1  cancel the current tile.
REQ-008 done_clear  in  1  clear sticky done/err_k_zero.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand stream handshake.
REQ-010 in_a  in  M x DW  A column for one k; in_b  in  N x DW  B row for one k.
REQ-011 step_valid / step_ready  out / in  1 / 1  array step handshake.
REQ-012 step_a  out  M x DW; step_b  out  N x DW  operands of the presented step.
REQ-013 k_first / k_last  out  1 / 1  step qualifiers, valid with step_valid.
REQ-014 k_idx  out  16  index of the presented step.
REQ-015 arr_idle  in  1  array pipeline empty (all issued steps retired).
REQ-016 busy, done, err_k_zero  out  1 each  status.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE + start + K>=1 SHALL go to RUN next cycle; latch K, acc_mode; zero in_cnt, k_idx; clear done and err_k_zero.
REQ-019 IDLE + start + K==0 SHALL go to DONE with err_k_zero=1; no in_ready or step_valid assertion.
REQ-020 in_ready SHALL be 1 only in RUN with FIFO not full and in_cnt<K; each in_valid&&in_ready pushes {in_a,in_b} and increments in_cnt.
REQ-021 step_valid SHALL be 1 only in RUN with FIFO not empty, combinationally from FIFO head; step_a/step_b SHALL equal head entry.
REQ-022 step_valid&&step_ready SHALL pop the FIFO and increment k_idx; step_valid SHALL hold its payload stable until accepted.
REQ-023 k_first SHALL be (k_idx==0)&&!acc_mode; with acc_mode=1 k_first SHALL never assert.
REQ-024 k_last SHALL be (k_idx==K-1).
REQ-025 Handshake with k_last=1 SHALL move RUN to DRAIN.
REQ-026 DRAIN SHALL move to DONE on the first cycle arr_idle=1 (observed the cycle after entering DRAIN or later); done=1 from the following cycle.
REQ-027 busy SHALL be 1 exactly in RUN and DRAIN.
REQ-028 DONE: done, err_k_zero sticky; done_clear returns to IDLE and clears both next cycle.
REQ-029 DONE + start same cycle as done_clear: start SHALL win (new tile launched, flags cleared).
REQ-030 DONE + start alone SHALL launch a new tile as from IDLE.
REQ-031 Simultaneous FIFO push and pop SHALL be legal at full and at empty (at full: pop frees the slot, push accepted only if in_ready was 1 that cycle, i.e. no pass-through at full).
REQ-032 abort in RUN or DRAIN SHALL return to IDLE next cycle, flush FIFO, clear counters, done stays 0; abort in IDLE/DONE ignored.
REQ-033 Pointer arithmetic SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-034 rst=0 at any clock edge SHALL force IDLE, empty FIFO, in_cnt=k_idx=0, busy=done=err_k_zero=0, in_ready=step_valid=0, mid-operation included.
REQ-035 FIFO storage SHALL not require reset; only pointers and count.

Structure
REQ-036 Package systolic_pkg SHALL hold the FSM state enum and the default DW constant.
REQ-037 FIFO SHALL be sub-module systolic_step_fifo, parametrised by width (M+N)*DW and DEPTH.

Verification
REQ-038 M=N=8, K=4, acc_mode=0, step_ready=1, 4 words streamed, arr_idle 2 cycles after last step -> exactly 4 step handshakes, k_first on k_idx=0 only, k_last on k_idx=3, done=1 the cycle after arr_idle sampled, busy=0.
REQ-039 DEPTH=4, K=8, step_ready=0 for 10 cycles, in_valid=1 -> in_ready drops after 4 pushes; on step_ready=1 all 8 steps issue in order with payload A00=3f800000,40000000,3f000000,40400000 repeating.
REQ-040 K=0, start -> no step_valid, done=1 and err_k_zero=1 within 2 cycles; done_clear -> both 0.
REQ-041 acc_mode=1, K=2 -> k_first never 1, k_last on second step, done asserted.
REQ-042 K=4, abort after 2 steps -> IDLE next cycle, busy=0, done=0, step_valid=0, FIFO empty; new start K=4 completes normally.
REQ-043 rst=0 during RUN with 3 words buffered -> all outputs at reset values next cycle; subsequent start K=2 issues exactly 2 steps.
